// File: rtl/fir_ctrl_pkg.sv
// Shared FIR definitions: controller state encoding and default widths.
// The tap-chain top uses the same defaults so the two always agree.
package fir_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_NUM_TAPS   = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file, one write per cycle; a flagged write also clears all higher entries.
// Output is the flattened bank, one cycle after the write; there is no backpressure.
module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int IDX_W      = $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_dat,
    input  logic                           zero_fill,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] weights
);

    logic [DATA_WIDTH-1:0] bank [NUM_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                bank[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (IDX_W'(k) == wr_idx) begin
                    bank[k] <= wr_dat;
                end else if (zero_fill && (IDX_W'(k) > wr_idx)) begin
                    bank[k] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign weights[g*DATA_WIDTH +: DATA_WIDTH] = bank[g];
    end

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencer: load coefficients, flush the taps with NUM_TAPS zeros, then one enable per sample.
// Result valid one cycle after acceptance; a held result (valid && !ready) stalls sample intake.
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_TAPS   = DEF_NUM_TAPS
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [DATA_WIDTH-1:0]          iv_coef,
    input  logic                           i_coef_valid,
    input  logic                           i_coef_last,
    output logic                           o_coef_ready,
    input  logic [DATA_WIDTH-1:0]          iv_sample,
    input  logic                           i_sample_valid,
    output logic                           o_sample_ready,
    input  logic                           i_reload,
    output logic [DATA_WIDTH-1:0]          ov_chain_din,
    output logic                           o_tap_en,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
    input  logic [DATA_WIDTH-1:0]          iv_chain_sum,
    output logic [DATA_WIDTH-1:0]          ov_result,
    output logic                           o_result_valid,
    input  logic                           i_result_ready,
    output logic                           o_busy
);

    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;
    logic             reload_pend, reload_pend_nxt;
    logic             result_valid_nxt;
    logic             coef_wr;
    logic             coef_end;

    assign coef_wr  = o_coef_ready && i_coef_valid;
    assign coef_end = i_coef_last || (idx == IDX_W'(NUM_TAPS - 1));

    fir_coef_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .wr_en     (coef_wr),
        .wr_idx    (idx),
        .wr_dat    (iv_coef),
        .zero_fill (coef_end),
        .weights   (ov_weights)
    );

    // The chain only shifts on o_tap_en, so its registered sum is already stable under stall.
    assign ov_result = iv_chain_sum;

    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        flush_cnt_nxt    = flush_cnt;
        reload_pend_nxt  = reload_pend;
        result_valid_nxt = o_result_valid;
        o_coef_ready     = 1'b0;
        o_sample_ready   = 1'b0;
        o_tap_en         = 1'b0;
        ov_chain_din     = '0;
        case (state)
            ST_LOAD: begin
                o_coef_ready = 1'b1;
                if (i_coef_valid) begin
                    if (coef_end) begin
                        idx_nxt   = '0;
                        state_nxt = ST_FLUSH;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                o_tap_en = 1'b1;
                if (flush_cnt == CNT_W'(NUM_TAPS - 1)) begin
                    flush_cnt_nxt = '0;
                    state_nxt     = ST_RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                o_sample_ready = !reload_pend && (!o_result_valid || i_result_ready);
                o_tap_en       = i_sample_valid && o_sample_ready;
                if (o_tap_en) begin
                    ov_chain_din = iv_sample;
                end
                if (i_reload) begin
                    reload_pend_nxt = 1'b1;
                end
                if (o_tap_en) begin
                    result_valid_nxt = 1'b1;
                end else if (i_result_ready) begin
                    result_valid_nxt = 1'b0;
                end
                // Leave only once the last result has drained downstream.
                if (reload_pend && !o_result_valid) begin
                    reload_pend_nxt = 1'b0;
                    state_nxt       = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_LOAD;
            idx            <= '0;
            flush_cnt      <= '0;
            reload_pend    <= 1'b0;
            o_result_valid <= 1'b0;
            o_busy         <= 1'b1;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            flush_cnt      <= flush_cnt_nxt;
            reload_pend    <= reload_pend_nxt;
            o_result_valid <= result_valid_nxt;
            o_busy         <= (state_nxt != ST_RUN);
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with NUM_TAPS=4; the tap chain is modelled as a register of din + 0x100.
module tb_fir_ctrl;

    localparam int DW = 24;
    localparam int NT = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  coef = '0;
    logic           coef_valid = 1'b0;
    logic           coef_last = 1'b0;
    logic           coef_ready;
    logic [DW-1:0]  sample = '0;
    logic           sample_valid = 1'b0;
    logic           sample_ready;
    logic           reload = 1'b0;
    logic [DW-1:0]  chain_din;
    logic           tap_en;
    logic [NT*DW-1:0] weights;
    logic [DW-1:0]  chain_sum;
    logic [DW-1:0]  result;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    fir_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .iv_coef        (coef),
        .i_coef_valid   (coef_valid),
        .i_coef_last    (coef_last),
        .o_coef_ready   (coef_ready),
        .iv_sample      (sample),
        .i_sample_valid (sample_valid),
        .o_sample_ready (sample_ready),
        .i_reload       (reload),
        .ov_chain_din   (chain_din),
        .o_tap_en       (tap_en),
        .ov_weights     (weights),
        .iv_chain_sum   (chain_sum),
        .ov_result      (result),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready),
        .o_busy         (busy)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_sum <= '0;
        else if (tap_en) chain_sum <= chain_din + 24'h000100;
    end

    always @(posedge clk) begin
        if (tap_en && sample_valid && !busy) acc_cnt <= acc_cnt + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL rst_coef_ready got %b want 1", coef_ready); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_sample_ready got %b want 0", sample_ready); end
        checks++; if (weights !== '0) begin errors++; $display("FAIL rst_weights got %h want 0", weights); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || coef_ready !== 1'b1 || tap_en !== 1'b0 || result_valid !== 1'b0 || chain_din !== '0)
            begin errors++; $display("FAIL post_rst_outputs got busy=%b cr=%b te=%b rv=%b din=%h want 1 1 0 0 0",
                busy, coef_ready, tap_en, result_valid, chain_din); end
    endtask

    task automatic test_full_load();
        logic [DW-1:0] c [NT];
        int n;
        c[0] = 24'h400000; c[1] = 24'h200000; c[2] = 24'h100000; c[3] = 24'h080000;
        for (int i = 0; i < NT; i++) begin
            if (i > 0) @(negedge clk);
            coef = c[i]; coef_valid = 1'b1; coef_last = 1'b0;
            #1;
            checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL load_ready_beat%0d got %b want 1", i, coef_ready); end
        end
        @(negedge clk);
        coef = 24'hABCDEF;
        #1;
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL ready_after_last got %b want 0", coef_ready); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (tap_en === 1'b1) begin
                n++;
                checks++; if (chain_din !== '0) begin errors++; $display("FAIL flush_din got %h want 0", chain_din); end
            end
            @(negedge clk);
            coef_valid = 1'b0;
        end
        checks++; if (n != NT) begin errors++; $display("FAIL flush_len got %0d want %0d", n, NT); end
        checks++; if (sample_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL run_entry got sr=%b busy=%b want 1 0", sample_ready, busy); end
        checks++; if (weights !== {24'h080000, 24'h100000, 24'h200000, 24'h400000})
            begin errors++; $display("FAIL full_weights got %h want 080000100000200000400000", weights); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] s [6];
        logic [DW-1:0] e [6];
        int start;
        s[0] = 24'h100000; s[1] = 24'h0FFFFF; s[2] = 24'h000001; s[3] = 24'h7FFF00; s[4] = 24'h800000; s[5] = 24'h00ABCD;
        e[0] = 24'h100100; e[1] = 24'h1000FF; e[2] = 24'h000101; e[3] = 24'h800000; e[4] = 24'h800100; e[5] = 24'h00ACCD;
        start = acc_cnt;
        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (result_valid !== 1'b1 || result !== e[i-1])
                    begin errors++; $display("FAIL stream_res%0d got v=%b %h want 1 %h", i-1, result_valid, result, e[i-1]); end
            end
            sample = s[i]; sample_valid = 1'b1;
            #1;
            checks++; if (tap_en !== 1'b1 || chain_din !== s[i])
                begin errors++; $display("FAIL stream_acc%0d got en=%b din=%h want 1 %h", i, tap_en, chain_din, s[i]); end
        end
        @(negedge clk);
        checks++; if (result_valid !== 1'b1 || result !== e[5]) begin errors++; $display("FAIL stream_res5 got %h want %h", result, e[5]); end
        result_ready = 1'b0; sample = 24'h000A00; sample_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (sample_ready !== 1'b0 || tap_en !== 1'b0 || result_valid !== 1'b1 || result !== e[5])
                begin errors++; $display("FAIL stall%0d got sr=%b en=%b v=%b res=%h want 0 0 1 %h", k, sample_ready, tap_en, result_valid, result, e[5]); end
            @(negedge clk);
        end
        result_ready = 1'b1;
        #1;
        checks++; if (tap_en !== 1'b1) begin errors++; $display("FAIL stall_release got en=%b want 1", tap_en); end
        @(negedge clk);
        checks++; if (result_valid !== 1'b1 || result !== 24'h000B00) begin errors++; $display("FAIL post_stall_res got %h want 000b00", result); end
        sample_valid = 1'b0;
        @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", result_valid); end
        checks++; if (acc_cnt - start != 7) begin errors++; $display("FAIL accepted_count got %0d want 7", acc_cnt - start); end
    endtask

    task automatic test_reload();
        @(negedge clk);
        result_ready = 1'b0; sample = 24'h000C00; sample_valid = 1'b1; reload = 1'b1;
        #1;
        checks++; if (tap_en !== 1'b1) begin errors++; $display("FAIL reload_same_cycle_acc got %b want 1", tap_en); end
        @(negedge clk);
        reload = 1'b0; sample_valid = 1'b0;
        checks++; if (result_valid !== 1'b1 || result !== 24'h000D00) begin errors++; $display("FAIL reload_res got v=%b %h want 1 000d00", result_valid, result); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reload_pend_blocks got %b want 0", sample_ready); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || coef_ready !== 1'b0) begin errors++; $display("FAIL reload_waits got busy=%b cr=%b want 0 0", busy, coef_ready); end
        result_ready = 1'b1;
        @(negedge clk);
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reload_handshake got v=%b busy=%b want 0 0", result_valid, busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || coef_ready !== 1'b1) begin errors++; $display("FAIL reload_to_load got busy=%b cr=%b want 1 1", busy, coef_ready); end
    endtask

    task automatic test_early_last();
        coef = 24'h7FFFFF; coef_valid = 1'b1; coef_last = 1'b0;
        @(negedge clk);
        coef = 24'h123456; coef_last = 1'b1;
        @(negedge clk);
        coef_valid = 1'b0; coef_last = 1'b0;
        checks++; if (weights !== {24'h000000, 24'h000000, 24'h123456, 24'h7FFFFF})
            begin errors++; $display("FAIL early_weights got %h want 000000000000123456 7fffff", weights); end
        checks++; if (busy !== 1'b1 || tap_en !== 1'b1) begin errors++; $display("FAIL early_flush got busy=%b en=%b want 1 1", busy, tap_en); end
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
        checks++; if (tap_en !== 1'b1) begin errors++; $display("FAIL early_flush4 got %b want 1", tap_en); end
        @(negedge clk);
        checks++; if (tap_en !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL early_run got en=%b sr=%b busy=%b want 0 1 0", tap_en, sample_ready, busy); end
        repeat (2) @(negedge clk);
        checks++; if (sample_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_reload_ignored got sr=%b busy=%b want 1 0", sample_ready, busy); end
    endtask

    task automatic test_reset_mid();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
        coef = 24'h111111; coef_valid = 1'b1;
        #1;
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL mid_load_ready got %b want 1", coef_ready); end
        @(negedge clk);
        coef = 24'h222222; coef_last = 1'b1;
        @(negedge clk);
        coef_valid = 1'b0; coef_last = 1'b0;
        checks++; if (weights[2*DW-1:0] !== {24'h222222, 24'h111111}) begin errors++; $display("FAIL mid_weights got %h want 222222111111", weights[2*DW-1:0]); end
        @(posedge clk);
        #1;
        checks++; if (tap_en !== 1'b1) begin errors++; $display("FAIL mid_flush2 got %b want 1", tap_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || coef_ready !== 1'b1 || sample_ready !== 1'b0 || tap_en !== 1'b0 || chain_din !== '0 || result_valid !== 1'b0)
            begin errors++; $display("FAIL async_rst_outputs got busy=%b cr=%b sr=%b en=%b din=%h v=%b want 1 1 0 0 0 0",
                busy, coef_ready, sample_ready, tap_en, chain_din, result_valid); end
        checks++; if (weights !== '0) begin errors++; $display("FAIL async_rst_weights got %h want 0", weights); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || coef_ready !== 1'b1 || tap_en !== 1'b0)
            begin errors++; $display("FAIL post_mid_rst got busy=%b cr=%b en=%b want 1 1 0", busy, coef_ready, tap_en); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stream();
        test_reload();
        test_early_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
